// File: rtl/vector_line_engine.sv
// Vector display line engine: accepts draw/jump commands and steers the
// X/Y DACs and beam enable. Draws use integer Bresenham stepping with a
// programmable number of clocks per step; jumps move the beam blanked and
// then wait for the DACs to settle.
module vector_line_engine #(
    parameter int WIDTH         = 12,
    parameter int STEP_DIV      = 1,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             draw,
    input  logic             jump,
    output logic             ready,
    output logic [WIDTH-1:0] dac_x,
    output logic [WIDTH-1:0] dac_y,
    output logic             beam_on
);

    // One shared down-counter serves both the step divider and the settle
    // wait; it only ever holds load values, so the larger load sets its width.
    localparam int CNT_MAX = (STEP_DIV > SETTLE_CYCLES) ? STEP_DIV : SETTLE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0]    STEP_LOAD   = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0]    SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;
    localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
    localparam logic [WIDTH-1:0] UNIT        = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        SETTLE
    } state_t;

    state_t                  state;
    logic [WIDTH-1:0]        tgt_x;
    logic [WIDTH-1:0]        tgt_y;
    logic                    is_jump;
    logic                    sx_neg;
    logic                    sy_neg;
    logic [CW-1:0]           count;
    logic signed [WIDTH+1:0] dx;
    logic signed [WIDTH+1:0] dy;
    logic signed [WIDTH+1:0] err;

    // Combinational helpers: deltas for line setup and the Bresenham decision.
    logic signed [WIDTH+1:0] diff_x;
    logic signed [WIDTH+1:0] diff_y;
    logic signed [WIDTH+1:0] abs_dx;
    logic signed [WIDTH+1:0] abs_dy;
    logic signed [WIDTH+2:0] e2;
    logic signed [WIDTH+2:0] dx_w;
    logic signed [WIDTH+2:0] dy_w;
    logic                    step_x;
    logic                    step_y;
    logic signed [WIDTH+1:0] err_step;
    logic                    at_target;

    // Setup deltas and the per-step error update; e2 gets one extra bit so
    // doubling a full-scale error term cannot overflow.
    always_comb begin
        diff_x    = $signed({2'b00, tgt_x}) - $signed({2'b00, dac_x});
        diff_y    = $signed({2'b00, tgt_y}) - $signed({2'b00, dac_y});
        abs_dx    = diff_x[WIDTH+1] ? -diff_x : diff_x;
        abs_dy    = diff_y[WIDTH+1] ? -diff_y : diff_y;
        e2        = {err, 1'b0};
        dx_w      = {dx[WIDTH+1], dx};
        dy_w      = {dy[WIDTH+1], dy};
        step_x    = (e2 >= dy_w);
        step_y    = (e2 <= dx_w);
        err_step  = err;
        if (step_x) begin
            err_step = err_step + dy;
        end
        if (step_y) begin
            err_step = err_step + dx;
        end
        at_target = (dac_x == tgt_x) && (dac_y == tgt_y);
    end

    // Command sequencer: IDLE -> SETUP -> DRAW | SETTLE -> IDLE, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ready   <= 1'b1;
            dac_x   <= '0;
            dac_y   <= '0;
            beam_on <= 1'b0;
            tgt_x   <= '0;
            tgt_y   <= '0;
            is_jump <= 1'b0;
            sx_neg  <= 1'b0;
            sy_neg  <= 1'b0;
            count   <= '0;
            dx      <= '0;
            dy      <= '0;
            err     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ready && (draw || jump)) begin
                        tgt_x   <= x;
                        tgt_y   <= y;
                        is_jump <= jump;
                        ready   <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (is_jump) begin
                        dac_x <= tgt_x;
                        dac_y <= tgt_y;
                        if (SETTLE_CYCLES == 0) begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end else begin
                            count <= SETTLE_LOAD;
                            state <= SETTLE;
                        end
                    end else begin
                        dx      <= abs_dx;
                        dy      <= -abs_dy;
                        sx_neg  <= diff_x[WIDTH+1];
                        sy_neg  <= diff_y[WIDTH+1];
                        err     <= abs_dx - abs_dy;
                        beam_on <= 1'b1;
                        count   <= STEP_LOAD;
                        state   <= DRAW;
                    end
                end
                DRAW: begin
                    if (count != '0) begin
                        count <= count - CNT_ONE;
                    end else if (at_target) begin
                        beam_on <= 1'b0;
                        ready   <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        if (step_x) begin
                            dac_x <= sx_neg ? (dac_x - UNIT) : (dac_x + UNIT);
                        end
                        if (step_y) begin
                            dac_y <= sy_neg ? (dac_y - UNIT) : (dac_y + UNIT);
                        end
                        err   <= err_step;
                        count <= STEP_LOAD;
                    end
                end
                SETTLE: begin
                    if (count == '0) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_line_engine.sv
// Scoreboard bench for vector_line_engine: two instances (STEP_DIV 1 and 3),
// a Bresenham point generator plus a timing model fill a queue of per-cycle
// expected {ready, beam_on, dac_x, dac_y} words that are popped each clock.
module tb_vector_line_engine;

    localparam int W      = 12;
    localparam int SETTLE = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         draw;
    logic         jump;
    int           sel;

    logic         draw_a, jump_a, draw_b, jump_b;
    logic         ready_a, beam_a, ready_b, beam_b;
    logic [W-1:0] dac_x_a, dac_y_a, dac_x_b, dac_y_b;
    logic [31:0]  obs_a, obs_b, obs;

    int           checks   = 0;
    int           failures = 0;
    logic [31:0]  exp_q[$];
    int           cur_x[2];
    int           cur_y[2];
    int           step_div[2];

    always #5 clk = ~clk;

    assign draw_a = draw && (sel == 0);
    assign jump_a = jump && (sel == 0);
    assign draw_b = draw && (sel == 1);
    assign jump_b = jump && (sel == 1);
    assign obs_a  = {6'b0, ready_a, beam_a, dac_x_a, dac_y_a};
    assign obs_b  = {6'b0, ready_b, beam_b, dac_x_b, dac_y_b};
    assign obs    = (sel == 0) ? obs_a : obs_b;

    vector_line_engine #(.WIDTH(W), .STEP_DIV(1), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .draw(draw_a), .jump(jump_a),
        .ready(ready_a), .dac_x(dac_x_a), .dac_y(dac_y_a), .beam_on(beam_a)
    );

    vector_line_engine #(.WIDTH(W), .STEP_DIV(3), .SETTLE_CYCLES(SETTLE)) dut3 (
        .clk(clk), .reset(reset), .x(x), .y(y), .draw(draw_b), .jump(jump_b),
        .ready(ready_b), .dac_x(dac_x_b), .dac_y(dac_y_b), .beam_on(beam_b)
    );

    function automatic logic [31:0] pack(input bit r, input bit b, input int px, input int py);
        logic [W-1:0] vx;
        logic [W-1:0] vy;
        vx = px[W-1:0];
        vy = py[W-1:0];
        return {6'b0, r, b, vx, vy};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got=%h want=%h", tag, $time, observed, expected);
        end
    endtask

    // Expected timeline of a draw: point k/D is shown D clocks each, endpoint included.
    task automatic pushDraw(input int inst, input int tx, input int ty);
        int px, py, dxv, dyv, sxv, syv, err, e2, n, d;
        int pts_x[$];
        int pts_y[$];
        px  = cur_x[inst];
        py  = cur_y[inst];
        dxv = (tx > px) ? tx - px : px - tx;
        dyv = -((ty > py) ? ty - py : py - ty);
        sxv = (tx >= px) ? 1 : -1;
        syv = (ty >= py) ? 1 : -1;
        err = dxv + dyv;
        pts_x.push_back(px);
        pts_y.push_back(py);
        while (px != tx || py != ty) begin
            e2 = 2 * err;
            if (e2 >= dyv) begin err += dyv; px += sxv; end
            if (e2 <= dxv) begin err += dxv; py += syv; end
            pts_x.push_back(px);
            pts_y.push_back(py);
        end
        n = pts_x.size() - 1;
        d = step_div[inst];
        exp_q.push_back(pack(0, 0, cur_x[inst], cur_y[inst]));
        for (int k = 0; k < (n + 1) * d; k++) begin
            exp_q.push_back(pack(0, 1, pts_x[k / d], pts_y[k / d]));
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(pack(1, 0, tx, ty));
        end
        cur_x[inst] = tx;
        cur_y[inst] = ty;
    endtask

    // Expected timeline of a jump: blanked move at E1, ready after the settle wait.
    task automatic pushJump(input int inst, input int tx, input int ty);
        exp_q.push_back(pack(0, 0, cur_x[inst], cur_y[inst]));
        for (int k = 0; k < SETTLE; k++) begin
            exp_q.push_back(pack(0, 0, tx, ty));
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(pack(1, 0, tx, ty));
        end
        cur_x[inst] = tx;
        cur_y[inst] = ty;
    endtask

    // Drive one command, optionally a busy strobe or reset at a given edge index, and check every clock.
    task automatic applyStimulus(input int inst, input int tx, input int ty, input bit do_draw,
                                 input bit do_jump, input int busy_at, input int reset_at);
        int          idx;
        int          prev_x, prev_y, ddx, ddy;
        bit          moving;
        bit          ok;
        logic [31:0] e;
        sel    = inst;
        x      = tx[W-1:0];
        y      = ty[W-1:0];
        draw   = do_draw;
        jump   = do_jump;
        moving = !do_jump;
        prev_x = cur_x[inst];
        prev_y = cur_y[inst];
        if (do_jump) pushJump(inst, tx, ty);
        else         pushDraw(inst, tx, ty);
        idx = 0;
        while (exp_q.size() > 0) begin
            if (idx == busy_at) begin
                draw = 1'b1;
                x    = 12'd100;
                y    = 12'd100;
            end
            if (idx == reset_at) reset = 1'b1;
            @(posedge clk);
            #1;
            draw = 1'b0;
            jump = 1'b0;
            if (reset) begin
                reset = 1'b0;
                checkOutput("abort_reset", obs, pack(1, 0, 0, 0));
                exp_q.delete();
                cur_x[0] = 0; cur_y[0] = 0;
                cur_x[1] = 0; cur_y[1] = 0;
            end else begin
                e = exp_q.pop_front();
                checkOutput("sequence", obs, e);
                if (moving) begin
                    ddx = int'(obs[23:12]) - prev_x;
                    ddy = int'(obs[11:0]) - prev_y;
                    ok  = (ddx >= -1) && (ddx <= 1) && (ddy >= -1) && (ddy <= 1);
                    checkOutput("step_delta", {31'b0, ok}, 32'd1);
                end
                prev_x = int'(obs[23:12]);
                prev_y = int'(obs[11:0]);
            end
            idx++;
        end
    endtask

    initial begin
        step_div[0] = 1;
        step_div[1] = 3;
        cur_x[0] = 0; cur_y[0] = 0;
        cur_x[1] = 0; cur_y[1] = 0;
        sel   = 0;
        reset = 1'b1;
        x     = '0;
        y     = '0;
        draw  = 1'b0;
        jump  = 1'b0;

        // Reset held three clocks, then five idle clocks
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_a", obs_a, pack(1, 0, 0, 0));
            checkOutput("reset_b", obs_b, pack(1, 0, 0, 0));
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idle_a", obs_a, pack(1, 0, 0, 0));
            checkOutput("idle_b", obs_b, pack(1, 0, 0, 0));
        end

        // Jump then a 50-step draw on both step rates
        applyStimulus(0, 50, 10, 1'b0, 1'b1, -1, -1);
        applyStimulus(0, 0, 40, 1'b1, 1'b0, -1, -1);
        applyStimulus(1, 50, 10, 1'b0, 1'b1, -1, -1);
        applyStimulus(1, 0, 40, 1'b1, 1'b0, -1, -1);

        // Zero-length draws (dots)
        applyStimulus(0, 0, 40, 1'b1, 1'b0, -1, -1);
        applyStimulus(1, 0, 40, 1'b1, 1'b0, -1, -1);

        // Busy strobe ignored; simultaneous draw+jump behaves as a jump
        applyStimulus(0, 20, 30, 1'b1, 1'b0, 5, -1);
        applyStimulus(0, 7, 9, 1'b1, 1'b1, -1, -1);

        // Full-scale draw aborted by reset, then a complete full-scale draw
        applyStimulus(0, 0, 0, 1'b0, 1'b1, -1, -1);
        applyStimulus(0, 4095, 4095, 1'b1, 1'b0, -1, 101);
        applyStimulus(0, 4095, 4095, 1'b1, 1'b0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
